// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the multi-channel divided-clock scheduler.
// The request struct and half_up() are sized for the widest supported divisor.
package clk_div_pkg;

    localparam int CW_DEFAULT      = 32;
    localparam int DEF_DIV_DEFAULT = 4;
    localparam int HW              = 64;

    typedef struct packed {
        logic [7:0]    ch;
        logic [HW-1:0] div;
        logic          en;
    } cfg_req_t;

    // Low-phase length ceil(D/2); one extra bit keeps D = all-ones from wrapping.
    function automatic logic [HW:0] half_up(input logic [HW-1:0] d);
        return ({1'b0, d} + 65'd1) >> 1;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, active divisor, run flag and a one-deep
// pending slot whose contents are swapped in only on the channel's wrap edge.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int CW      = CW_DEFAULT,
    parameter int DEF_DIV = DEF_DIV_DEFAULT
) (
    input  logic          clk_in,
    input  logic          rst_n,
    input  logic          wr,
    input  logic [CW-1:0] wr_div,
    input  logic          wr_en,
    output logic          tick,
    output logic          clk_out,
    output logic          pend
);

    logic [CW-1:0] cnt, cnt_n, d_act, d_n, slot_div, slot_div_n;
    logic          en, en_n, pend_n, slot_en, slot_en_n, wrap;

    assign wrap = en && (cnt == d_act - CW'(1));

    always_comb begin
        // NOTE: every output of this block is defaulted first, so no path infers a latch.
        cnt_n      = cnt;
        d_n        = d_act;
        en_n       = en;
        pend_n     = pend;
        slot_div_n = slot_div;
        slot_en_n  = slot_en;
        if (!en) begin
            if (wr) begin
                d_n  = wr_div;
                en_n = wr_en;
            end
        end else begin
            cnt_n = wrap ? '0 : cnt + CW'(1);
            if (wrap && pend) begin
                d_n    = slot_div;
                en_n   = slot_en;
                pend_n = 1'b0;
            end
            // A write only reaches a running channel while pend is clear, so a
            // write on a wrap edge is parked for the following wrap.
            if (wr) begin
                slot_div_n = wr_div;
                slot_en_n  = wr_en;
                pend_n     = 1'b1;
            end
        end
        if (!en_n) cnt_n = '0;
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            d_act    <= CW'(DEF_DIV);
            en       <= 1'b0;
            pend     <= 1'b0;
            slot_div <= '0;
            slot_en  <= 1'b0;
            tick     <= 1'b0;
            clk_out  <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so all channels
            // see the same pre-edge values regardless of evaluation order.
            cnt      <= cnt_n;
            d_act    <= d_n;
            en       <= en_n;
            pend     <= pend_n;
            slot_div <= slot_div_n;
            slot_en  <= slot_en_n;
            tick     <= wrap && en_n;
            clk_out  <= en_n && (65'(cnt_n) >= half_up(64'(d_n)));
        end
    end

endmodule

// File: rtl/clk_div_sched.sv
// Multi-channel divided-clock scheduler: config decode, validity check,
// per-channel ready mux and the reject pulse around NCH clk_div_chan instances.
module clk_div_sched
    import clk_div_pkg::*;
#(
    parameter  int NCH     = 4,
    parameter  int CW      = CW_DEFAULT,
    parameter  int DEF_DIV = DEF_DIV_DEFAULT,
    localparam int CHW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk_in,
    input  logic           rst_n,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    input  logic [CHW-1:0] cfg_ch,
    input  logic [CW-1:0]  cfg_div,
    input  logic           cfg_en,
    output logic           cfg_err,
    output logic [NCH-1:0] pend,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] clk_out
);

    cfg_req_t req;
    logic     ch_bad, div_bad, sel_pend, xfer, accept;

    assign req     = '{ch: 8'(cfg_ch), div: 64'(cfg_div), en: cfg_en};
    assign ch_bad  = int'(req.ch) >= NCH;
    assign div_bad = req.en && (req.div == '0);

    always_comb begin
        sel_pend = 1'b0;
        for (int i = 0; i < NCH; i++)
            if (req.ch == 8'(i)) sel_pend = pend[i];
    end

    // Out-of-range channels are always ready so the reject can be reported.
    assign cfg_ready = !sel_pend || ch_bad;
    assign xfer      = cfg_valid && cfg_ready;
    assign accept    = xfer && !ch_bad && !div_bad;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) cfg_err <= 1'b0;
        else        cfg_err <= xfer && (ch_bad || div_bad);
    end

    for (genvar g = 0; g < NCH; g++) begin : g_chan
        clk_div_chan #(
            .CW      (CW),
            .DEF_DIV (DEF_DIV)
        ) u_chan (
            .clk_in  (clk_in),
            .rst_n   (rst_n),
            .wr      (accept && (req.ch == 8'(g))),
            .wr_div  (req.div[CW-1:0]),
            .wr_en   (req.en),
            .tick    (tick[g]),
            .clk_out (clk_out[g]),
            .pend    (pend[g])
        );
    end

endmodule

// File: tb/tb_clk_div_sched.sv
// Self-checking bench for clk_div_sched: directed scenarios followed by random
// config traffic, compared every cycle against a period-position reference model.
module tb_clk_div_sched;

    localparam int NCH     = 3;
    localparam int CW      = 8;
    localparam int DEF_DIV = 4;
    localparam int CHW     = 2;

    logic           clk_in = 1'b0;
    logic           rst_n;
    logic           cfg_valid;
    logic           cfg_ready;
    logic [CHW-1:0] cfg_ch;
    logic [CW-1:0]  cfg_div;
    logic           cfg_en;
    logic           cfg_err;
    logic [NCH-1:0] pend, tick, clk_out;

    clk_div_sched #(.NCH(NCH), .CW(CW), .DEF_DIV(DEF_DIV)) dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_en    (cfg_en),
        .cfg_err   (cfg_err),
        .pend      (pend),
        .tick      (tick),
        .clk_out   (clk_out)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: per channel, divisor, run flag, position inside the
    // current period and the parked request.
    int m_d[NCH], m_pos[NCH], m_sd[NCH];
    bit m_en[NCH], m_pend[NCH], m_se[NCH], m_tick[NCH], m_clk[NCH];
    bit m_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_ready();
        if (int'(cfg_ch) >= NCH) return 1'b1;
        return !m_pend[cfg_ch];
    endfunction

    function automatic logic [63:0] vec(input bit v[NCH]);
        logic [63:0] r = '0;
        for (int i = 0; i < NCH; i++) r[i] = v[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_d[i] = DEF_DIV; m_pos[i] = 0; m_sd[i] = 0;
            m_en[i] = 0; m_pend[i] = 0; m_se[i] = 0; m_tick[i] = 0; m_clk[i] = 0;
        end
        m_err = 0;
    endtask

    // Advance the model by one clk_in edge using the inputs present at that edge.
    task automatic model_step();
        bit xfer, bad, acc, period_end;
        xfer  = cfg_valid && model_ready();
        bad   = (int'(cfg_ch) >= NCH) || (cfg_en && cfg_div == 0);
        acc   = xfer && !bad;
        m_err = xfer && bad;
        for (int i = 0; i < NCH; i++) begin
            bit hit = acc && (int'(cfg_ch) == i);
            m_tick[i] = 0;
            if (!m_en[i]) begin
                if (hit) begin m_d[i] = int'(cfg_div); m_en[i] = cfg_en; m_pos[i] = 0; end
            end else begin
                period_end = (m_pos[i] == m_d[i] - 1);
                m_tick[i]  = period_end;
                m_pos[i]   = period_end ? 0 : m_pos[i] + 1;
                if (period_end && m_pend[i]) begin
                    m_d[i] = m_sd[i]; m_en[i] = m_se[i]; m_pend[i] = 0;
                end
                if (hit) begin m_sd[i] = int'(cfg_div); m_se[i] = cfg_en; m_pend[i] = 1; end
            end
            if (!m_en[i]) begin m_pos[i] = 0; m_tick[i] = 0; end
            m_clk[i] = m_en[i] && (m_pos[i] >= (m_d[i] + 1) / 2);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".tick"},    64'(tick),    vec(m_tick));
        check({tag, ".clk_out"}, 64'(clk_out), vec(m_clk));
        check({tag, ".pend"},    64'(pend),    vec(m_pend));
        check({tag, ".cfg_err"}, 64'(cfg_err), 64'(m_err));
    endtask

    // Entered one time unit after an edge; returns one time unit after the next.
    task automatic cycle();
        #1 check("cfg_ready", 64'(cfg_ready), 64'(model_ready()));
        @(posedge clk_in);
        model_step();
        #1 check_outputs("cyc");
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    // Hold a request with cfg_valid until the model says it is taken.
    task automatic send(input int ch, input int div, input bit en);
        bit taken = 0;
        cfg_valid = 1; cfg_ch = CHW'(ch); cfg_div = CW'(div); cfg_en = en;
        for (int k = 0; k < 600 && !taken; k++) begin
            taken = model_ready();
            cycle();
        end
        cfg_valid = 0;
        if (!taken) begin
            n_checks++; n_fail++;
            $display("FAIL send_timeout: ch %0d not accepted, required acceptance", ch);
        end
    endtask

    task automatic wait_until_pos(input int ch, input int pos);
        int k = 0;
        while (m_pos[ch] != pos && k < 600) begin cycle(); k++; end
        if (m_pos[ch] != pos) begin
            n_checks++; n_fail++;
            $display("FAIL wait_pos: ch %0d pos %0d, required %0d", ch, m_pos[ch], pos);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; cfg_valid = 0; cfg_ch = '0; cfg_div = '0; cfg_en = 0;
        model_reset();
        #3 check_outputs("reset");
        #19 rst_n = 1;
        run(3);

        // Basic divisors: D=4 on ch0, D=5 on ch1.
        send(0, 4, 1);
        run(12);
        send(1, 5, 1);
        run(12);

        // ch1 to D=4, then a mid-period change to D=10 parks until the wrap.
        send(1, 4, 1);
        run(12);
        wait_until_pos(1, 1);
        send(1, 10, 1);
        run(25);

        // Rejects, then D=1 on ch2.
        send(2, 0, 1);
        run(2);
        send(3, 6, 1);
        run(2);
        send(2, 1, 1);
        run(6);

        // Back-to-back writes to ch0 while the first is still pending.
        wait_until_pos(0, 1);
        send(0, 6, 1);
        send(0, 3, 1);
        run(20);

        // Largest divisor on ch0 after a clean stop.
        send(0, 0, 0);
        send(0, 255, 1);
        run(520);

        // Async reset mid-period with a pending update.
        wait_until_pos(1, 2);
        send(1, 7, 1);
        run(1);
        rst_n = 0;
        model_reset();
        #1 check_outputs("async_rst");
        @(posedge clk_in);
        #1 check_outputs("in_rst");
        #2 rst_n = 1;
        run(6);

        // Random config traffic.
        for (int k = 0; k < 3000; k++) begin
            int r = $urandom_range(0, 19);
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_ch    = CHW'($urandom_range(0, 3));
            cfg_div   = (r == 0) ? 8'd0 : (r == 1) ? 8'd255 : CW'($urandom_range(1, 9));
            cfg_en    = ($urandom_range(0, 4) != 0);
            cycle();
        end
        cfg_valid = 0;
        run(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
